uart_stream_arbiter: RTL and testbench

UART_STREAM_ARBITER -- requirements
Module: uart_stream_arbiter

---
 rtl/uart_stream_pkg.sv | 27 ++
 rtl/uart_stream_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_stream_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_stream_pkg
// Purpose  : Shared FSM state type and packet sizing for uart_stream_arbiter.
// Revision : 1.0  initial release
// ============================================================================
package uart_stream_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int unsigned MONO_BYTES = 3;
    localparam int unsigned DUAL_BYTES = 5;
    localparam int unsigned PKT_W      = 8 * DUAL_BYTES;

    // Index of the final byte of a packet of the given kind.
    function automatic logic [2:0] last_index(input logic dual);
        return dual ? 3'(DUAL_BYTES - 1) : 3'(MONO_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_stream_arbiter
// Purpose  : Packs mono or decimated dual audio samples into framed byte
//            packets and hands them one at a time to a UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
module uart_stream_arbiter
    import uart_stream_pkg::*;
#(
    parameter int unsigned DUAL_DECIM = 2,
    parameter logic [7:0]  MONO_HDR   = 8'hA5,
    parameter logic [7:0]  DUAL_HDR   = 8'h5A
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        mode_in,
    input  logic [15:0] mono_data_in,
    input  logic        mono_valid_in,
    input  logic [31:0] dual_data_in,
    input  logic        dual_valid_in,
    input  logic        tx_busy_in,
    output logic [7:0]  byte_out,
    output logic        byte_trigger_out,
    output logic        busy_out,
    output logic [15:0] drop_count_out
);

    localparam int unsigned c_dcnt_w = (DUAL_DECIM > 1) ? $clog2(DUAL_DECIM) : 1;
    localparam logic [c_dcnt_w-1:0] c_decim_last = c_dcnt_w'(DUAL_DECIM - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_mode_prev;
    logic [c_dcnt_w-1:0]   r_decim_cnt;
    logic [c_dcnt_w-1:0]   w_decim_base;
    logic [c_dcnt_w-1:0]   w_decim_nxt;
    logic                  r_pend_valid;
    logic                  r_pend_dual;
    logic [31:0]           r_pend_data;
    logic [15:0]           r_drop_cnt;
    logic [PKT_W-1:0]      r_shift;
    logic [2:0]            r_byte_idx;
    logic                  r_pkt_dual;

    logic                  w_mode_change;
    logic                  w_flush;
    logic                  w_mono_acc;
    logic                  w_dual_strobe;
    logic                  w_dual_fwd;
    logic                  w_accept;
    logic [31:0]           w_accept_data;
    logic                  w_drop;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_trigger;
    logic                  w_last;

    // ------------------------------------------------------------------
    // Source selection and decimation
    // ------------------------------------------------------------------
    assign w_mode_change = (mode_in != r_mode_prev);
    assign w_flush       = w_mode_change | ~enable_in;
    assign w_mono_acc    = enable_in & ~mode_in & mono_valid_in;
    assign w_dual_strobe = enable_in &  mode_in & dual_valid_in;

    // A mode switch restarts decimation, including for a strobe in that cycle.
    always_comb begin
        w_decim_base = w_mode_change ? '0 : r_decim_cnt;
        w_decim_nxt  = w_decim_base;
        if (w_dual_strobe) begin
            w_decim_nxt = (w_decim_base == c_decim_last) ? '0 : w_decim_base + 1'b1;
        end
    end

    assign w_dual_fwd    = w_dual_strobe & (w_decim_base == '0);
    assign w_accept      = w_mono_acc | w_dual_fwd;
    assign w_accept_data = mode_in ? dual_data_in : {16'h0000, mono_data_in};

    // Overwriting a live sample is a drop; replacing one that is leaving now is not.
    assign w_drop = w_accept & r_pend_valid & ~w_load & ~w_flush;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mode_prev  <= 1'b0;
            r_decim_cnt  <= '0;
            r_pend_valid <= 1'b0;
            r_pend_dual  <= 1'b0;
            r_pend_data  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_mode_prev <= mode_in;
            r_decim_cnt <= w_decim_nxt;
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_dual  <= mode_in;
                r_pend_data  <= w_accept_data;
            end else if (w_load || w_flush) begin
                r_pend_valid <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet sequencer
    // ------------------------------------------------------------------
    assign w_last = (r_byte_idx == last_index(r_pkt_dual));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_trigger   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_valid && !tx_busy_in) begin
                    w_state_nxt = ISSUE;
                    w_load      = 1'b1;
                end
            end
            ISSUE: begin
                w_trigger   = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy_in) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_in) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_advance   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Header sits in the low byte so byte_out is always the bottom of the shifter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_pkt_dual <= 1'b0;
        end else if (w_load) begin
            r_shift    <= {r_pend_data, (r_pend_dual ? DUAL_HDR : MONO_HDR)};
            r_byte_idx <= 3'd0;
            r_pkt_dual <= r_pend_dual;
        end else if (w_advance) begin
            r_shift    <= {8'h00, r_shift[PKT_W-1:8]};
            r_byte_idx <= r_byte_idx + 3'd1;
        end
    end

    assign byte_out         = r_shift[7:0];
    assign byte_trigger_out = w_trigger;
    assign busy_out         = (r_state != IDLE);
    assign drop_count_out   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_stream_arbiter
// Purpose  : Directed and randomized self-checking bench for uart_stream_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_stream_arbiter;

    localparam int unsigned DECIM = 2;

    logic        clk_in        = 1'b0;
    logic        rst_in        = 1'b0;
    logic        enable_in     = 1'b0;
    logic        mode_in       = 1'b0;
    logic [15:0] mono_data_in  = '0;
    logic        mono_valid_in = 1'b0;
    logic [31:0] dual_data_in  = '0;
    logic        dual_valid_in = 1'b0;
    logic        tx_busy_in    = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_trigger_out;
    logic        busy_out;
    logic [15:0] drop_count_out;

    always #5 clk_in = ~clk_in;

    uart_stream_arbiter #(
        .DUAL_DECIM (DECIM),
        .MONO_HDR   (8'hA5),
        .DUAL_HDR   (8'h5A)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .mode_in          (mode_in),
        .mono_data_in     (mono_data_in),
        .mono_valid_in    (mono_valid_in),
        .dual_data_in     (dual_data_in),
        .dual_valid_in    (dual_valid_in),
        .tx_busy_in       (tx_busy_in),
        .byte_out         (byte_out),
        .byte_trigger_out (byte_trigger_out),
        .busy_out         (busy_out),
        .drop_count_out   (drop_count_out)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic        busy_arm  = 1'b0;
    int          busy_left = 0;
    logic [7:0]  held_byte = '0;
    logic        prev_trig = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: goes busy one cycle after a trigger, for ten cycles.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            tx_busy_in = 1'b0;
            busy_arm   = 1'b0;
            busy_left  = 0;
            prev_trig  = 1'b0;
        end else begin
            if (tx_busy_in) chk("byte_hold", {24'd0, byte_out}, {24'd0, held_byte});
            if (busy_arm) begin
                tx_busy_in = 1'b1;
                busy_left  = 10;
                busy_arm   = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy_in = 1'b0;
            end
            if (byte_trigger_out) begin
                chk("trig_single", {31'd0, prev_trig}, 32'd0);
                rx_q.push_back(byte_out);
                held_byte = byte_out;
                busy_arm  = 1'b1;
            end
            prev_trig = byte_trigger_out;
        end
    end

    // Reference packet: header then payload bytes least significant first.
    task automatic expect_pkt(input logic dual, input logic [31:0] d);
        int nb;
        nb = dual ? 4 : 2;
        exp_q.push_back(dual ? 8'h5A : 8'hA5);
        for (int i = 0; i < nb; i++) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic check_rx(input string tag);
        int n;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse(input logic mono, input logic dual, input logic [31:0] d);
        @(negedge clk_in);
        mono_data_in  = d[15:0];
        dual_data_in  = d;
        mono_valid_in = mono;
        dual_valid_in = dual;
        @(negedge clk_in);
        mono_valid_in = 1'b0;
        dual_valid_in = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int run;
        int n;
        run = 0;
        n   = 0;
        while (run < 4 && n < 3000) begin
            @(negedge clk_in);
            n++;
            if (!busy_out && !tx_busy_in) run++;
            else run = 0;
        end
        chk({tag, "_quiet"}, {31'd0, (run >= 4)}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in        = 1'b0;
        enable_in     = 1'b1;
        mode_in       = 1'b0;
        mono_valid_in = 1'b0;
        dual_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        rx_q.delete();
        exp_q.delete();
        @(negedge clk_in);
    endtask

    int          dcnt;
    int          r;
    int          n;
    logic [31:0] d;

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_byte", {24'd0, byte_out}, 32'd0);
        chk("rst_trig", {31'd0, byte_trigger_out}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_drop", {16'd0, drop_count_out}, 32'd0);
        rst_in    = 1'b1;
        enable_in = 1'b1;
        @(negedge clk_in);

        // Mono 16'h1234: two-cycle trigger latency, then A5 34 12.
        pulse(1'b1, 1'b0, 32'h0000_1234);
        chk("lat_early", {31'd0, byte_trigger_out}, 32'd0);
        @(negedge clk_in);
        chk("lat_trig", {31'd0, byte_trigger_out}, 32'd1);
        chk("lat_hdr", {24'd0, byte_out}, 32'hA5);
        chk("lat_busy", {31'd0, busy_out}, 32'd1);
        wait_quiet("mono");
        expect_pkt(1'b0, 32'h0000_1234);
        check_rx("mono");

        // Dual with decimation 2: four strobes give two packets.
        @(negedge clk_in);
        mode_in = 1'b1;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1, 32'hAABB_CCDD);
            wait_quiet("dual");
        end
        expect_pkt(1'b1, 32'hAABB_CCDD);
        expect_pkt(1'b1, 32'hAABB_CCDD);
        check_rx("dual");

        // Three strobes during one packet: first sent, last sent next, one drop.
        do_reset();
        pulse(1'b1, 1'b0, 32'h0000_1111);
        repeat (4) @(negedge clk_in);
        pulse(1'b1, 1'b0, 32'h0000_2222);
        repeat (4) @(negedge clk_in);
        pulse(1'b1, 1'b0, 32'h0000_3333);
        wait_quiet("drop");
        chk("drop_cnt", {16'd0, drop_count_out}, 32'd1);
        expect_pkt(1'b0, 32'h0000_1111);
        expect_pkt(1'b0, 32'h0000_3333);
        check_rx("drop");

        // Mode toggle mid packet: pending mono cleared, foreign strobe ignored.
        do_reset();
        pulse(1'b1, 1'b0, 32'h0000_4444);
        repeat (3) @(negedge clk_in);
        pulse(1'b1, 1'b0, 32'h0000_5555);
        pulse(1'b0, 1'b1, 32'h1234_5678);
        repeat (3) @(negedge clk_in);
        mode_in = 1'b1;
        wait_quiet("modesw");
        chk("modesw_drop", {16'd0, drop_count_out}, 32'd0);
        expect_pkt(1'b0, 32'h0000_4444);
        check_rx("modesw");

        // Enable low clears a pending sample.
        do_reset();
        pulse(1'b1, 1'b0, 32'h0000_6666);
        repeat (3) @(negedge clk_in);
        pulse(1'b1, 1'b0, 32'h0000_7777);
        enable_in = 1'b0;
        @(negedge clk_in);
        enable_in = 1'b1;
        wait_quiet("enable");
        expect_pkt(1'b0, 32'h0000_6666);
        check_rx("enable");

        // Reset in WAIT_DONE of byte 2; next packet starts with a header.
        do_reset();
        pulse(1'b1, 1'b0, 32'h0000_BEEF);
        n = 0;
        while (rx_q.size() < 2 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("mid_reach", {31'd0, (rx_q.size() >= 2)}, 32'd1);
        repeat (3) @(negedge clk_in);
        chk("mid_busy", {31'd0, busy_out}, 32'd1);
        chk("mid_byte", {24'd0, byte_out}, 32'hEF);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_byte", {24'd0, byte_out}, 32'd0);
        chk("arst_trig", {31'd0, byte_trigger_out}, 32'd0);
        chk("arst_busy", {31'd0, busy_out}, 32'd0);
        chk("arst_drop", {16'd0, drop_count_out}, 32'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        rx_q.delete();
        exp_q.delete();
        pulse(1'b1, 1'b0, 32'h0000_CAFE);
        wait_quiet("post_rst");
        expect_pkt(1'b0, 32'h0000_CAFE);
        check_rx("post_rst");

        // Strobe in the consume cycle becomes the next packet, no drop.
        do_reset();
        @(negedge clk_in);
        mono_data_in  = 16'h0A0B;
        mono_valid_in = 1'b1;
        @(negedge clk_in);
        mono_data_in  = 16'h0C0D;
        @(negedge clk_in);
        mono_valid_in = 1'b0;
        wait_quiet("b2b");
        chk("b2b_drop", {16'd0, drop_count_out}, 32'd0);
        expect_pkt(1'b0, 32'h0000_0A0B);
        expect_pkt(1'b0, 32'h0000_0C0D);
        check_rx("b2b");

        // Randomized: both sources strobe together, random mode switches and disables.
        do_reset();
        dcnt = 0;
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            d = $urandom();
            if (r < 3) begin
                @(negedge clk_in);
                mode_in = ~mode_in;
                dcnt    = 0;
                repeat (2) @(negedge clk_in);
            end
            if (r == 9) begin
                enable_in = 1'b0;
                pulse(1'b1, 1'b1, d);
                enable_in = 1'b1;
            end else begin
                pulse(1'b1, 1'b1, d);
                if (!mode_in) begin
                    expect_pkt(1'b0, {16'd0, d[15:0]});
                end else begin
                    if (dcnt == 0) expect_pkt(1'b1, d);
                    dcnt = (dcnt + 1) % DECIM;
                end
            end
            wait_quiet("rand");
            check_rx("rand");
        end
        chk("rand_drop", {16'd0, drop_count_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
